// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 2-flop synchronizer, mid-bit 2-of-3 majority voting,
// LSB-first framing with one start and one stop bit, registered valid / frame-error pulses.
module uart_rx_oversampled #(
    parameter int OVERSAMPLE = 6,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SAMPLE_0  = TW'(2);
    localparam logic [TW-1:0] SAMPLE_1  = TW'(3);
    localparam logic [TW-1:0] SAMPLE_2  = TW'(4);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic                 rx_meta_q;
    logic                 rxs_q;
    state_t               state_q,     state_d;
    logic [TW-1:0]        tick_cnt_q,  tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [2:0]           samples_q,   samples_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] data_q,      data_d;
    logic                 valid_q,     valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 majority;

    assign majority = (samples_q[0] & samples_q[1]) |
                      (samples_q[0] & samples_q[2]) |
                      (samples_q[1] & samples_q[2]);

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samples_d   = samples_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (tick_i) begin
            if (state_q == IDLE) begin
                // The tick that first sees the line low is tick 0 of the start bit.
                if (!rxs_q) begin
                    state_d    = START;
                    tick_cnt_d = TW'(1);
                end
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
                if (tick_cnt_q == SAMPLE_0) samples_d[0] = rxs_q;
                if (tick_cnt_q == SAMPLE_1) samples_d[1] = rxs_q;
                if (tick_cnt_q == SAMPLE_2) samples_d[2] = rxs_q;

                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    unique case (state_q)
                        START: begin
                            if (!majority) begin
                                state_d   = DATA;
                                bit_cnt_d = '0;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                        DATA: begin
                            shift_d = {majority, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt_q == BIT_LAST) begin
                                state_d = STOP;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                            end
                        end
                        STOP: begin
                            if (majority) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end else begin
                                frame_err_d = 1'b1;
                            end
                            state_d = IDLE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    // The data and shift registers are plain flops, so they take a reset value like everything else.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            samples_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop see pre-edge values of the others.
            rx_meta_q   <= rx_i;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            samples_q   <= samples_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 50 MHz clock, tick every 4th clock (24 clocks per bit).
// Frames are launched aligned to a tick so mid-bit glitch and break timing are deterministic.
module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       tick_i = 1'b0;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] data_hist [16];
    int         tick_div = 0;
    bit         tick_en = 1'b1;

    uart_rx_oversampled #(
        .OVERSAMPLE(6),
        .DATA_BITS (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .tick_i     (tick_i),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .busy_o     (busy_o)
    );

    always #10 clk = ~clk;

    // Tick changes on the falling edge, so it is stable at every rising edge.
    always @(negedge clk) begin
        tick_div = (tick_div == 3) ? 0 : tick_div + 1;
        tick_i   = tick_en && (tick_div == 0);
    end

    always @(negedge clk) begin
        if (valid_o) begin
            data_hist[valid_cnt % 16] = data_o;
            valid_cnt++;
        end
        if (frame_err_o) ferr_cnt++;
        if (valid_o && frame_err_o) both_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic align_to_tick();
        do clocks(1); while (tick_i !== 1'b1);
    endtask

    // One frame, 24 clocks per bit; glitch_bit >= 0 inverts that data bit around its middle sample.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit);
        rx_i = 1'b0;
        clocks(24);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            if (i == glitch_bit) begin
                clocks(12);
                rx_i = ~b[i];
                clocks(4);
                rx_i = b[i];
                clocks(8);
            end else begin
                clocks(24);
            end
        end
        rx_i = stop_v;
        clocks(24);
        rx_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        rx_i  = 1'b1;
        clocks(3);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        rst_i = 1'b0;
        clocks(10);
    endtask

    task automatic test_good_frame();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        align_to_tick();
        send_frame(8'hA5, 1'b1, -1);
        clocks(8);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL good_valid_count: got %0d expected 1", valid_cnt - v0); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL good_data: got %h expected a5", data_o); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL good_ferr_count: got %0d expected 0", ferr_cnt - f0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL good_busy_after: got %b expected 0", busy_o); end
    endtask

    task automatic test_false_start();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        align_to_tick();
        rx_i = 1'b0;
        clocks(4);
        rx_i = 1'b1;
        clocks(4);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL false_start_busy_high: got %b expected 1", busy_o); end
        clocks(30);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL false_start_busy_low: got %b expected 0", busy_o); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL false_start_valid: got %0d expected 0", valid_cnt - v0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL false_start_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_error();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        align_to_tick();
        send_frame(8'h3C, 1'b0, -1);
        clocks(8);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", valid_cnt - v0); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %h expected a5", data_o); end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        align_to_tick();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        clocks(8);
        checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); end
        checks++; if (data_hist[v0 % 16] !== 8'h00) begin errors++; $display("FAIL b2b_first_data: got %h expected 00", data_hist[v0 % 16]); end
        checks++; if (data_hist[(v0 + 1) % 16] !== 8'hFF) begin errors++; $display("FAIL b2b_second_data: got %h expected ff", data_hist[(v0 + 1) % 16]); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_majority();
        int v0 = valid_cnt;
        align_to_tick();
        send_frame(8'h5A, 1'b1, 2);
        clocks(8);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL majority_valid_count: got %0d expected 1", valid_cnt - v0); end
        checks++; if (data_o !== 8'h5A) begin errors++; $display("FAIL majority_data: got %h expected 5a", data_o); end
    endtask

    // Two full 240-clock frames of low line, released just before a third start would be taken.
    task automatic test_break();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        align_to_tick();
        rx_i = 1'b0;
        clocks(480);
        rx_i = 1'b1;
        clocks(30);
        checks++; if (ferr_cnt - f0 !== 2) begin errors++; $display("FAIL break_ferr_count: got %0d expected 2", ferr_cnt - f0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL break_valid: got %0d expected 0", valid_cnt - v0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL break_busy_after: got %b expected 0", busy_o); end
        checks++; if (data_o !== 8'h5A) begin errors++; $display("FAIL break_data_kept: got %h expected 5a", data_o); end
    endtask

    task automatic test_tick_hold();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        align_to_tick();
        rx_i = 1'b0;
        clocks(6);
        tick_en = 1'b0;
        clocks(200);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b expected 1", busy_o); end
        rx_i    = 1'b1;
        tick_en = 1'b1;
        clocks(40);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL hold_abort_busy: got %b expected 0", busy_o); end
        checks++; if ((valid_cnt - v0) + (ferr_cnt - f0) !== 0) begin errors++; $display("FAIL hold_pulses: got %0d expected 0", (valid_cnt - v0) + (ferr_cnt - f0)); end
    endtask

    task automatic test_reset_mid_frame();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        align_to_tick();
        rx_i = 1'b0;
        clocks(24);
        for (int i = 0; i < 4; i++) begin
            rx_i = (i == 0);
            clocks(24);
        end
        rx_i = 1'b0;
        clocks(12);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy_o); end
        rst_i = 1'b1;
        clocks(2);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy_in_reset: got %b expected 0", busy_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL midrst_data_in_reset: got %h expected 00", data_o); end
        rst_i = 1'b0;
        rx_i  = 1'b1;
        clocks(200);
        checks++; if ((valid_cnt - v0) + (ferr_cnt - f0) !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d expected 0", (valid_cnt - v0) + (ferr_cnt - f0)); end
        align_to_tick();
        send_frame(8'h81, 1'b1, -1);
        clocks(8);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_valid_count: got %0d expected 1", valid_cnt - v0); end
        checks++; if (data_o !== 8'h81) begin errors++; $display("FAIL midrst_data: got %h expected 81", data_o); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_majority();
        test_break();
        test_tick_hold();
        test_reset_mid_frame();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulses_exclusive: got %0d overlapping cycles expected 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 6, meaning tick_i pulses per serial bit period.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, sent LSB first.
REQ-003 SHALL have port clk_i  input  1  system clock (50 MHz); the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tick_i  input  1  one-clk_i-cycle enable at OVERSAMPLE x baud (6 x 9600).
REQ-006 SHALL have port rx_i  input  1  asynchronous serial line; idles high.
REQ-007 SHALL have port data_o  output  DATA_BITS  last correctly framed byte received.
REQ-008 SHALL have port valid_o  output  1  one-cycle pulse when data_o is updated.
REQ-009 SHALL have port frame_err_o  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass rx_i through a 2-flop synchronizer whose flops reset to 1; all decisions SHALL use the synchronized value rxs.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; state, counters and the shift register SHALL change only on clk_i edges where tick_i=1, except the valid_o/frame_err_o pulses.
REQ-013 SHALL use tick_cnt, range 0..OVERSAMPLE-1, to count ticks within a bit, and bit_cnt, range 0..DATA_BITS-1, to count data bits.
REQ-014 IDLE: a tick with rxs=0 SHALL move to START with tick_cnt=1; this tick counts as tick 0 of the start bit.
REQ-015 In START, DATA and STOP, every tick SHALL increment tick_cnt, and rxs SHALL be captured at tick_cnt = 2, 3 and 4 (mid-bit).
REQ-016 On the tick where tick_cnt=OVERSAMPLE-1, the bit value SHALL be the 2-of-3 majority of the captured samples, and tick_cnt SHALL wrap to 0.
REQ-017 START end: majority 0 SHALL move to DATA with bit_cnt=0; majority 1 (false start or glitch) SHALL return to IDLE with no output pulse.
REQ-018 DATA end of bit: the majority bit SHALL shift in at the MSB of the shift register, right-shifting so the first bit lands at LSB; bit_cnt=DATA_BITS-1 SHALL move to STOP, otherwise bit_cnt increments.
REQ-019 STOP end: majority 1 SHALL load data_o from the shift register and assert valid_o; majority 0 SHALL assert frame_err_o and leave data_o unchanged; both cases SHALL go to IDLE.
REQ-020 valid_o and frame_err_o SHALL be registered, high for exactly the one clk_i cycle after the deciding tick edge, and never high together.
REQ-021 Absent tick_i, the FSM and counters SHALL hold indefinitely.
REQ-022 A held-low line (break) SHALL produce one frame_err_o per 10-bit-period frame, repeating while the line stays low; no valid_o.
REQ-023 A back-to-back frame whose start edge falls on the first tick after the STOP decision SHALL be received without loss.
REQ-024 busy_o SHALL be a combinational decode of state != IDLE.

Reset
REQ-025 rst_i=1 SHALL immediately force state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, data_o=0, valid_o=0, frame_err_o=0, busy_o=0, and synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte with no pulse; after release, reception SHALL resume from the next falling start edge.

Verification
REQ-027 tick_i every 4th clk_i (24 clk per bit); send 0xA5 with a good stop bit -> exactly one valid_o pulse, data_o=0xA5, frame_err_o never high.
REQ-028 rx_i low for 1 tick only, then high -> START aborts to IDLE; no valid_o, no frame_err_o; busy_o returns low.
REQ-029 Send 0x3C with the stop bit driven low -> one frame_err_o pulse; data_o keeps its previous value (0xA5); no valid_o.
REQ-030 0x00 then 0xFF back-to-back (zero idle time) -> two valid_o pulses with data_o=0x00 then 0xFF.
REQ-031 0x5A with the line inverted at tick_cnt=3 of data bit 2 -> majority corrects it; data_o=0x5A.
REQ-032 Assert rst_i during data bit 4 of a frame, then release and send 0x81 -> no pulse for the aborted frame; data_o=0x81 with one valid_o.
